// File: rtl/mul_fa_cell.sv
// One-bit full adder: the repeating cell of the array multiplier's reduction rows.
module mul_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/array_mul_usign.sv
// Registered unsigned N x M array multiplier: AND-gate partial products reduced by
// M-1 ripple-carry rows of full adders, between an input and an output register.
module array_mul_usign #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   B,
  output logic [N+M-1:0] Y,
  output logic           out_valid
);

  logic [N-1:0]   a_p0;
  logic [M-1:0]   b_p0;
  logic           vld_p0;
  logic [N+M-1:0] prod;

  // Unpacked per-bit arrays keep each cell's wiring independent of its neighbours.
  logic row_sum  [M][N];
  logic row_cout [M];

  // ---- stage 0: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        a_p0 <= A;
        b_p0 <= B;
      end
    end
  end

  genvar i, j;

  generate
    for (j = 0; j < N; j++) begin : g_row0
      assign row_sum[0][j] = a_p0[j] & b_p0[0];
    end
    assign row_cout[0] = 1'b0;

    // Row i adds pp row i to the previous row shifted down by one; its carry-out
    // becomes the top bit of what row i+1 sees.
    for (i = 1; i < M; i++) begin : g_row
      logic c [N+1];
      assign c[0] = 1'b0;
      for (j = 0; j < N; j++) begin : g_cell
        logic up;
        if (j < N - 1) begin : g_mid
          assign up = row_sum[i-1][j+1];
        end else begin : g_top
          assign up = row_cout[i-1];
        end
        mul_fa_cell u_fa (
          .a    (a_p0[j] & b_p0[i]),
          .b    (up),
          .cin  (c[j]),
          .s    (row_sum[i][j]),
          .cout (c[j+1])
        );
      end
      assign row_cout[i] = c[N];
    end

    for (i = 0; i < M; i++) begin : g_lo
      assign prod[i] = row_sum[i][0];
    end
    for (j = 0; j < N - 1; j++) begin : g_hi
      assign prod[M+j] = row_sum[M-1][j+1];
    end
    assign prod[N+M-1] = row_cout[M-1];
  endgenerate

  // ---- stage 1: product register (holds when no new sample) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        Y <= prod;
      end
    end
  end

endmodule

// File: tb/tb_array_mul_usign.sv
// Directed and randomised checks of array_mul_usign at 8x8 and 12x5.
module tb_array_mul_usign;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [15:0] y;
  logic        out_valid;

  logic        in_valid2 = 1'b0;
  logic [11:0] a2 = '0;
  logic [4:0]  b2 = '0;
  logic [16:0] y2;
  logic        out_valid2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ca [5] = '{8'd0, 8'd1, 8'd255, 8'd128, 8'd255};
  logic [7:0]  cb [5] = '{8'd200, 8'd173, 8'd1, 8'd2, 8'd255};
  logic [63:0] ce [5] = '{64'd0, 64'd173, 64'd255, 64'd256, 64'd65025};

  logic        m_v0, m_v1;
  logic [63:0] m_p0, m_p1, m_y;

  array_mul_usign #(.N(8), .M(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .Y(y), .out_valid(out_valid)
  );

  array_mul_usign #(.N(12), .M(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2),
    .A(a2), .B(b2), .Y(y2), .out_valid(out_valid2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with a valid max pair on the inputs.
    a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_y", 64'(y), 64'd0);
      check("rst_vld", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_vld0", 64'(out_valid), 64'd0);
    check("post_rst_y0", 64'(y), 64'd0);
    in_valid = 1'b0;
    tick();
    check("post_rst_vld1", 64'(out_valid), 64'd1);
    check("post_rst_y1", 64'(y), 64'd65025);
    tick();

    // Corner pairs back to back.
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        a_in = ca[k]; b_in = cb[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k > 0) begin
        check("corner_vld", 64'(out_valid), 64'd1);
        check("corner_y", 64'(y), ce[k-1]);
      end
    end

    // Hold: one sample then idle with toggling operands.
    a_in = 8'd13; b_in = 8'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom);
    tick();
    check("hold_vld_pulse", 64'(out_valid), 64'd1);
    check("hold_y0", 64'(y), 64'd143);
    for (int k = 0; k < 10; k++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      tick();
      check("hold_vld", 64'(out_valid), 64'd0);
      check("hold_y", 64'(y), 64'd143);
    end

    // Random stream with gaps, checked against a two-stage model.
    m_v0 = 1'b0; m_p0 = '0; m_y = 64'd143;
    for (int k = 0; k < 1000; k++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      tick();
      m_v1 = m_v0; m_p1 = m_p0;
      m_v0 = in_valid; m_p0 = 64'(a_in) * 64'(b_in);
      if (m_v1) m_y = m_p1;
      check("rand_vld", 64'(out_valid), 64'(m_v1));
      check("rand_y", 64'(y), m_y);
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Reset while 200x200 is in flight.
    a_in = 8'd200; b_in = 8'd200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_y_async", 64'(y), 64'd0);
    check("midrst_vld_async", 64'(out_valid), 64'd0);
    tick();
    check("midrst_y", 64'(y), 64'd0);
    check("midrst_vld", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_after_vld", 64'(out_valid), 64'd0);
    check("midrst_after_y", 64'(y), 64'd0);

    // Asymmetric 12x5 instance.
    a2 = 12'd4095; b2 = 5'd31; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    check("asym_vld", 64'(out_valid2), 64'd1);
    check("asym_max", 64'(y2), 64'd126945);
    m_v0 = 1'b0; m_p0 = '0; m_y = 64'd126945;
    for (int k = 0; k < 500; k++) begin
      a2 = 12'($urandom); b2 = 5'($urandom);
      in_valid2 = ($urandom_range(0, 3) != 0);
      tick();
      m_v1 = m_v0; m_p1 = m_p0;
      m_v0 = in_valid2; m_p0 = 64'(a2) * 64'(b2);
      if (m_v1) m_y = m_p1;
      check("asym_rand_vld", 64'(out_valid2), 64'(m_v1));
      check("asym_rand_y", 64'(y2), m_y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
